// File: rtl/am_lock_multi_rx.sv
// am_lock_multi_rx: clause-82 alignment-marker lock for one PCS lane; optional AM_LOCK_CNT_EN adds am_err_cnt_o
module am_lock_multi_rx #(
    parameter int BLOCK_W     = 66,
    parameter int LANE_N      = 4,
    parameter int GAP_N       = 16383,
    parameter int INVALID_MAX = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [BLOCK_W-1:0] block_i,
    output logic               slip_v_o,
    output logic               lock_v_o,
    output logic               am_v_o,
    output logic [LANE_N-1:0]  lane_o
`ifdef AM_LOCK_CNT_EN
    ,
    output logic [15:0]        am_err_cnt_o
`endif
);
    localparam int LW = (LANE_N > 1) ? $clog2(LANE_N) : 1;
    localparam logic [14:0] GAP = 15'(GAP_N);
    localparam logic [3:0] INV_LAST = 4'(INVALID_MAX - 1);

    typedef enum logic [1:0] {FIND, CHECK, LOCKED} state_t;

    function automatic logic [23:0] am_code(input int l);
        am_code = 24'h0;
        if (LANE_N == 20) begin
            case (l)
                0:  am_code = 24'h2168c1;
                1:  am_code = 24'h8e719d;
                2:  am_code = 24'he84b59;
                3:  am_code = 24'h7b954d;
                4:  am_code = 24'h0907f5;
                5:  am_code = 24'hc214dd;
                6:  am_code = 24'h264a9a;
                7:  am_code = 24'h66457b;
                8:  am_code = 24'h7624a0;
                9:  am_code = 24'hfbc968;
                10: am_code = 24'h996cfd;
                11: am_code = 24'h5591b9;
                12: am_code = 24'hb2b95c;
                13: am_code = 24'hbdf81a;
                14: am_code = 24'hcac783;
                15: am_code = 24'hcd3635;
                16: am_code = 24'h4c31c4;
                17: am_code = 24'hb7d6ad;
                18: am_code = 24'h2a665f;
                19: am_code = 24'he5f0c0;
                default: am_code = 24'h0;
            endcase
        end else begin
            case (l)
                0: am_code = 24'h477690;
                1: am_code = 24'he6c4f0;
                2: am_code = 24'h9b65c5;
                3: am_code = 24'h3d79a2;
                default: am_code = 24'h0;
            endcase
        end
    endfunction

    // BIP bytes carry parity only and never take part in marker identification
    function automatic logic is_am(input logic [BLOCK_W-1:0] b, input logic [23:0] c);
        is_am = b[65:64] == 2'b10 && b[23:0] == c && b[55:32] == ~c;
    endfunction

    state_t            state, state_n;
    logic [14:0]       cnt;
    logic [3:0]        inv;
    logic [LW-1:0]     lane, hit_lane;
    logic              hit, good, at_pos;
    logic              find_hit, chk_ok, chk_bad, lk_ok, lk_bad, lose;
    logic              slip_n, am_n, lock_n;
    logic [LANE_N-1:0] lane_n;
    logic              bip_unused;

    assign bip_unused = ^{block_i[63:56], block_i[31:24]};

    // marker search across all lanes (lowest index wins) and check against the stored lane
    always_comb begin
        hit = 1'b0;
        hit_lane = '0;
        for (int l = LANE_N - 1; l >= 0; l--)
            if (is_am(block_i, am_code(l))) begin
                hit = 1'b1;
                hit_lane = LW'(l);
            end
        at_pos = valid_i && cnt == GAP;
        good = is_am(block_i, am_code(int'(lane)));
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= FIND;
        else       state <= state_n;
    end

    // next-state decisions
    always_comb begin
        find_hit = state == FIND && valid_i && hit;
        chk_ok   = state == CHECK && at_pos && good;
        chk_bad  = state == CHECK && at_pos && !good;
        lk_ok    = state == LOCKED && at_pos && good;
        lk_bad   = state == LOCKED && at_pos && !good;
        lose     = lk_bad && inv == INV_LAST;
        state_n  = find_hit ? CHECK :
                   chk_ok   ? LOCKED :
                   (chk_bad || lose) ? FIND : state;
    end

    // output values for the next cycle
    always_comb begin
        slip_n = chk_bad || lose;
        am_n   = lk_ok;
        lock_n = state_n == LOCKED;
        lane_n = lock_n ? LANE_N'(1) << lane : '0;
    end

    // position/invalid counters, stored lane and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            inv      <= '0;
            lane     <= '0;
            slip_v_o <= 1'b0;
            am_v_o   <= 1'b0;
            lock_v_o <= 1'b0;
            lane_o   <= '0;
        end else begin
            if (find_hit) lane <= hit_lane;
            cnt      <= (find_hit || at_pos) ? 15'd0 : valid_i ? cnt + 15'd1 : cnt;
            inv      <= (lk_ok || lose) ? 4'd0 : lk_bad ? inv + 4'd1 : inv;
            slip_v_o <= slip_n;
            am_v_o   <= am_n;
            lock_v_o <= lock_n;
            lane_o   <= lane_n;
        end
    end

`ifdef AM_LOCK_CNT_EN
    // saturating lifetime count of invalid markers seen while locked
    always_ff @(posedge clk) begin
        if (reset)                             am_err_cnt_o <= '0;
        else if (lk_bad && am_err_cnt_o != '1) am_err_cnt_o <= am_err_cnt_o + 16'd1;
    end
`endif
endmodule

// File: tb/tb_am_lock_multi_rx.sv
// tb_am_lock_multi_rx: directed bench with a marker-index reference model for am_lock_multi_rx
module tb_am_lock_multi_rx;
    localparam int G = 4095;
    localparam int IMAX = 4;

    logic        clk = 1'b0;
    logic        reset, valid_i;
    logic [65:0] block_i;
    logic        slip_v_o, lock_v_o, am_v_o;
    logic [3:0]  lane_o;
`ifdef AM_LOCK_CNT_EN
    logic [15:0] am_err_cnt_o;
`endif

    am_lock_multi_rx #(.GAP_N(G), .INVALID_MAX(IMAX)) dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .block_i(block_i),
        .slip_v_o(slip_v_o), .lock_v_o(lock_v_o), .am_v_o(am_v_o), .lane_o(lane_o)
`ifdef AM_LOCK_CNT_EN
        , .am_err_cnt_o(am_err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] m0 [4] = '{8'h90, 8'hf0, 8'hc5, 8'ha2};
    logic [7:0] m1 [4] = '{8'h76, 8'hc4, 8'h65, 8'h79};
    logic [7:0] m2 [4] = '{8'h47, 8'he6, 8'h9b, 8'h3d};

    int lit_checks = 0, lit_err = 0, cmp_checks = 0, cmp_err = 0;
    bit armed = 0;

    // reference model: tracks absolute valid-block indices of expected markers
    int phase = 0, lane_m = 0, due = 0, vidx = 0, bad_run = 0, err_total = 0;
    logic e_slip = 0, e_am = 0, e_lock = 0;
    logic [3:0] e_lane = 0;

    function automatic int lane_of(input logic [65:0] b);
        lane_of = -1;
        for (int l = 3; l >= 0; l--)
            if (b[65:64] == 2'b10 && b[7:0] == m0[l] && b[15:8] == m1[l] && b[23:16] == m2[l] &&
                b[39:32] == ~m0[l] && b[47:40] == ~m1[l] && b[55:48] == ~m2[l])
                lane_of = l;
    endfunction

    always @(posedge clk) begin
        int l;
        if (reset) begin
            phase = 0; bad_run = 0; err_total = 0; vidx = 0;
            e_slip = 0; e_am = 0;
        end else begin
            e_slip = 0; e_am = 0;
            if (valid_i) begin
                l = lane_of(block_i);
                if (phase == 0) begin
                    if (l >= 0) begin lane_m = l; due = vidx + G + 1; phase = 1; end
                end else if (vidx == due) begin
                    due = vidx + G + 1;
                    if (phase == 1) begin
                        if (l == lane_m) begin phase = 2; bad_run = 0; end
                        else begin e_slip = 1; phase = 0; end
                    end else if (l == lane_m) begin
                        bad_run = 0; e_am = 1;
                    end else begin
                        bad_run++;
                        if (err_total < 65535) err_total++;
                        if (bad_run == IMAX) begin e_slip = 1; phase = 0; bad_run = 0; end
                    end
                end
                vidx++;
            end
        end
        e_lock = phase == 2;
        e_lane = phase == 2 ? 4'(1 << lane_m) : 4'd0;
    end

    // per-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (armed) begin
            cmp_checks++;
            if ({slip_v_o, am_v_o, lock_v_o, lane_o} !== {e_slip, e_am, e_lock, e_lane}
`ifdef AM_LOCK_CNT_EN
                || am_err_cnt_o !== 16'(err_total)
`endif
            ) begin
                cmp_err++;
                if (cmp_err <= 10)
                    $display("FAIL model t=%0t slip/am/lock/lane got %b/%b/%b/%b expected %b/%b/%b/%b",
                             $time, slip_v_o, am_v_o, lock_v_o, lane_o, e_slip, e_am, e_lock, e_lane);
            end
        end
    end

    function automatic logic [65:0] mk(input int l, input bit bad);
        logic [65:0] b;
        b = {2'b10, 8'($urandom), ~m2[l], ~m1[l], ~m0[l], 8'($urandom), m2[l], m1[l], m0[l]};
        if (bad) b[12] = ~b[12];
        return b;
    endfunction

    function automatic logic [65:0] rnd();
        return {($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, 32'($urandom), 32'($urandom)};
    endfunction

    task automatic step(input bit v, input logic [65:0] b);
        valid_i = v;
        block_i = b;
        @(negedge clk);
    endtask

    task automatic fill(input int n);
        repeat (n) step(1'b1, rnd());
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        lit_checks++;
        if (act !== exp) begin
            lit_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid_i = 1'b0;
        block_i = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        armed = 1;
        chk("reset_lock", 32'(lock_v_o), 0);
        chk("reset_lane", 32'(lane_o), 0);
        chk("reset_slip", 32'(slip_v_o), 0);
        chk("reset_am", 32'(am_v_o), 0);

        step(1'b1, mk(2, 0));
        chk("t1_cand_lock", 32'(lock_v_o), 0);
        fill(G);
        step(1'b1, mk(2, 0));
        chk("t1_lock", 32'(lock_v_o), 1);
        chk("t1_lane", 32'(lane_o), 32'h4);

        do_reset();
        step(1'b1, mk(1, 0));
        fill(G);
        step(1'b1, mk(3, 0));
        chk("t2_slip", 32'(slip_v_o), 1);
        chk("t2_lock", 32'(lock_v_o), 0);
        step(1'b1, rnd());
        chk("t2_slip_end", 32'(slip_v_o), 0);

        do_reset();
        step(1'b1, mk(0, 0));
        fill(G);
        step(1'b1, mk(0, 0));
        chk("t3_lock", 32'(lane_o), 32'h1);
        for (int i = 0; i < 3; i++) begin
            fill(G);
            step(1'b1, mk(0, 1));
        end
        chk("t3_hold_lock", 32'(lock_v_o), 1);
        chk("t3_hold_am", 32'(am_v_o), 0);
        fill(G);
        step(1'b1, mk(0, 0));
        chk("t3_good_am", 32'(am_v_o), 1);
        for (int i = 0; i < 4; i++) begin
            fill(G);
            step(1'b1, mk(0, 1));
            if (i == 2) chk("t3_pre_lock", 32'(lock_v_o), 1);
        end
        chk("t3_lost_lock", 32'(lock_v_o), 0);
        chk("t3_lost_slip", 32'(slip_v_o), 1);
        chk("t3_lost_lane", 32'(lane_o), 0);
`ifdef AM_LOCK_CNT_EN
        chk("t3_err_cnt", 32'(am_err_cnt_o), 7);
`endif

        step(1'b1, mk(0, 0));
        fill(G);
        step(1'b1, mk(0, 0));
        for (int i = 0; i < G; i++) begin
            if (i == 10 || i == 1000 || i == 2000 || i == 3000) step(1'b0, rnd());
            step(1'b1, rnd());
        end
        step(1'b0, mk(0, 0));
        chk("t4_gap_am", 32'(am_v_o), 0);
        chk("t4_gap_lock", 32'(lock_v_o), 1);
        step(1'b1, mk(0, 0));
        chk("t4_am", 32'(am_v_o), 1);

        step(1'b1, rnd());
        do_reset();
        step(1'b1, mk(3, 0));
        fill(2000);
        reset = 1'b1;
        step(1'b1, mk(3, 0));
        reset = 1'b0;
        chk("t5_rst_all", 32'({slip_v_o, am_v_o, lock_v_o, lane_o}), 0);
        step(1'b1, mk(3, 0));
        fill(G);
        step(1'b1, mk(3, 0));
        chk("t5_relock", 32'(lock_v_o), 1);
        chk("t5_lane", 32'(lane_o), 32'h8);
`ifdef AM_LOCK_CNT_EN
        chk("t5_err_cnt", 32'(am_err_cnt_o), 0);
`endif
        step(1'b1, rnd());

        $display("Simulation finished: %0d checks, %0d errors", cmp_checks + lit_checks, cmp_err + lit_err);
        $finish;
    end
endmodule
